// File: rtl/upg_pkg.sv
// ---------------------------------------------------------------------------
// upg_pkg
// Shared definitions for the serial program loader: the loader control-state
// encodings, the checksum seed and the default bit period.
// Optional feature macro used by the loader: UPG_CHECKSUM_EN
// ---------------------------------------------------------------------------
package upg_pkg;

    // 10 MHz clock / 115200 baud
    localparam int UPG_CLKS_PER_BIT_DEF = 87;

    // Seed for the running XOR over the frame bytes
    localparam logic [7:0] CSUM_INIT = 8'h00;

    // Loader control states; UPG_CSUM is only reachable with UPG_CHECKSUM_EN
    typedef enum logic [2:0] {
        UPG_IDLE   = 3'd0,
        UPG_LEN_LO = 3'd1,
        UPG_LEN_HI = 3'd2,
        UPG_DATA   = 3'd3,
        UPG_CSUM   = 3'd4,
        UPG_DONE   = 3'd5,
        UPG_ERR    = 3'd6
    } upg_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
// 8N1 byte receiver: 2-flop synchronizer, bit timer and shift register.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   rx_i           - asynchronous serial input, idles high
//   byte_o         - last received byte (valid while byte_valid_o is high)
//   byte_valid_o   - one-cycle pulse, the cycle after the stop-bit sample
//   frame_err_o    - one-cycle pulse when the stop bit is sampled low
// ---------------------------------------------------------------------------
module uart_rx_byte
    import upg_pkg::*;
#(
    parameter int CLKS_PER_BIT = UPG_CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t        r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic             r_valid;
    logic             r_frameErr;

    // Receiver: the line is synchronized, then a falling edge seen while idle
    // starts the bit timer. The start bit is re-checked half a bit later so a
    // short low glitch drops back to idle; after that every sample lands in
    // the middle of a bit. Returning to idle at the stop-bit midpoint leaves
    // half a bit of margin to catch a start bit that follows immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_prev     <= 1'b1;
            r_state    <= RX_IDLE;
            r_cnt      <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_sync1    <= rx_i;
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (!r_sync2 && r_prev) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        if (r_sync2) begin
                            r_state <= RX_IDLE;
                        end else begin
                            r_state  <= RX_DATA;
                            r_bitIdx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_bitIdx == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_sync2) begin
                            r_valid <= 1'b1;
                        end else begin
                            r_frameErr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign byte_o       = r_shift;
    assign byte_valid_o = r_valid;
    assign frame_err_o  = r_frameErr;

endmodule

// File: rtl/uart_program_loader.sv
// ---------------------------------------------------------------------------
// uart_program_loader
// Serial boot loader driving the UART-programmer port of the program/data
// RAMs. Receives a length-prefixed frame (LEN_LO, LEN_HI, 4*N data bytes),
// packs little-endian 32-bit words and issues one-cycle write strobes.
// Optional feature macro: UPG_CHECKSUM_EN - a trailing XOR checksum byte
// covering the length and data bytes must match before DONE.
// Ports:
//   clk, rst     - clock (also the RAM upg_clk_i), synchronous active-high reset
//   rx_i         - asynchronous serial input, idles high
//   start_i      - one-cycle pulse entering programming mode
//   upg_rst_o    - high only while idle; low while the loader owns the RAM
//   upg_wen_o    - one-cycle RAM write strobe
//   upg_adr_o    - word address of the write
//   upg_dat_o    - write data
//   upg_done_o   - load complete, sticky until start_i or rst
//   upg_err_o    - framing/length/checksum error, sticky until start_i or rst
// ---------------------------------------------------------------------------
module uart_program_loader
    import upg_pkg::*;
#(
    parameter int CLKS_PER_BIT = UPG_CLKS_PER_BIT_DEF,
    parameter int ADDR_W       = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    input  logic              start_i,
    output logic              upg_rst_o,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              upg_err_o
);

    // The word counter must reach N itself, which can be 2^ADDR_W
    localparam int LEN_W     = (ADDR_W + 1 > 16) ? ADDR_W + 1 : 16;
    localparam int MAX_WORDS = 1 << ADDR_W;

`ifdef UPG_CHECKSUM_EN
    localparam upg_state_t POST_DATA = UPG_CSUM;
`else
    localparam upg_state_t POST_DATA = UPG_DONE;
`endif

    logic [7:0]  w_byte;
    logic        w_byteValid;
    logic        w_frameErr;
    logic [15:0] w_lenFull;
    logic        w_inFrame;
    logic        w_canStart;

    upg_state_t        r_state;
    logic [7:0]        r_lenLo;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_wordCnt;
    logic [1:0]        r_byteCnt;
    logic [23:0]       r_shift;
    logic              r_upgRst;
    logic              r_wen;
    logic [ADDR_W-1:0] r_adr;
    logic [31:0]       r_dat;
    logic              r_done;
    logic              r_err;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .byte_o       (w_byte),
        .byte_valid_o (w_byteValid),
        .frame_err_o  (w_frameErr)
    );

    assign w_lenFull  = {w_byte, r_lenLo};
    assign w_inFrame  = (r_state == UPG_LEN_LO) || (r_state == UPG_LEN_HI) ||
                        (r_state == UPG_DATA)   || (r_state == UPG_CSUM);
    assign w_canStart = (r_state == UPG_IDLE) || (r_state == UPG_DONE) ||
                        (r_state == UPG_ERR);

    // Frame parser and word assembler. start_i wins over everything else so a
    // restart from DONE/ERR always begins cleanly. Bytes are shifted in from
    // the top so that after three bytes r_shift holds {b2,b1,b0}; the fourth
    // byte completes the word directly into the write register. Completion
    // after data passes through DONE for one cycle before upg_done_o rises,
    // which puts the done edge one cycle after the final write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= UPG_IDLE;
            r_lenLo   <= '0;
            r_len     <= '0;
            r_wordCnt <= '0;
            r_byteCnt <= '0;
            r_shift   <= '0;
            r_upgRst  <= 1'b1;
            r_wen     <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef UPG_CHECKSUM_EN
            r_csum    <= CSUM_INIT;
`endif
        end else begin
            r_wen <= 1'b0;
            if (start_i && w_canStart) begin
                r_state   <= UPG_LEN_LO;
                r_upgRst  <= 1'b0;
                r_done    <= 1'b0;
                r_err     <= 1'b0;
                r_wordCnt <= '0;
                r_byteCnt <= '0;
                r_shift   <= '0;
`ifdef UPG_CHECKSUM_EN
                r_csum    <= CSUM_INIT;
`endif
            end else if (w_frameErr && w_inFrame) begin
                r_state <= UPG_ERR;
                r_err   <= 1'b1;
            end else if (r_state == UPG_DONE) begin
                r_done <= 1'b1;
            end else if (w_byteValid) begin
`ifdef UPG_CHECKSUM_EN
                r_csum <= r_csum ^ w_byte;
`endif
                case (r_state)
                    UPG_LEN_LO: begin
                        r_lenLo <= w_byte;
                        r_state <= UPG_LEN_HI;
                    end
                    UPG_LEN_HI: begin
                        r_len <= LEN_W'(w_lenFull);
                        if (32'(w_lenFull) > MAX_WORDS) begin
                            r_state <= UPG_ERR;
                            r_err   <= 1'b1;
                        end else if (w_lenFull == 16'd0) begin
                            r_state <= POST_DATA;
                        end else begin
                            r_state <= UPG_DATA;
                        end
                    end
                    UPG_DATA: begin
                        r_byteCnt <= r_byteCnt + 1'b1;
                        if (r_byteCnt == 2'd3) begin
                            r_wen     <= 1'b1;
                            r_adr     <= r_wordCnt[ADDR_W-1:0];
                            r_dat     <= {w_byte, r_shift};
                            r_wordCnt <= r_wordCnt + 1'b1;
                            if (r_wordCnt + 1'b1 == r_len) begin
                                r_state <= POST_DATA;
                            end
                        end else begin
                            r_shift <= {w_byte, r_shift[23:8]};
                        end
                    end
`ifdef UPG_CHECKSUM_EN
                    UPG_CSUM: begin
                        if (w_byte == r_csum) begin
                            r_state <= UPG_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= UPG_ERR;
                            r_err   <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign upg_rst_o  = r_upgRst;
    assign upg_wen_o  = r_wen;
    assign upg_adr_o  = r_adr;
    assign upg_dat_o  = r_dat;
    assign upg_done_o = r_done;
    assign upg_err_o  = r_err;

endmodule
